// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES constants, FSM state type and S-box lookup functions
// Purpose: shared definitions for inv_subbytes_iter and inv_sbox.
//   AES_STATE_W / AES_BYTES : state geometry
//   state_e                 : IDLE / BUSY / DONE
//   sbox_inv / sbox_fwd     : byte lookups into the FIPS-197 tables
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Row 0 sits in the MSBs, so entry b lives at bits [2047-8*b -: 8].
  localparam logic [2047:0] SBOX_INV_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [2047:0] SBOX_FWD_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV_TBL[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD_TBL[2047 - 8*int'(b) -: 8];
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// rtl/inv_sbox.sv - combinational AES inverse S-box for one byte
// Ports:
//   i_byte : byte to substitute
//   o_byte : InvSbox(i_byte)
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  assign o_byte = sbox_inv(i_byte);

endmodule

// File: rtl/inv_subbytes_iter.sv
// rtl/inv_subbytes_iter.sv - iterative AES (Inv)SubBytes, BYTES_PER_CYCLE bytes per cycle
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake for in_state and mode
//   in_state [127:0]    : AES state, byte i at [i*8 +: 8]
//   mode                : 0 = inverse S-box, 1 = forward S-box (latched at accept)
//   out_valid/out_ready : output handshake for out_state
//   out_state [127:0]   : substituted state, same byte mapping
// Build option: INV_SUBBYTES_FWD_EN adds forward tables and honours mode;
//   without it mode is ignored and every operation is inverse.
module inv_subbytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  localparam int N_CHUNKS = AES_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int CHUNK_W  = 8 * BYTES_PER_CYCLE;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

  state_e                   r_state;
  state_e                   w_next_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [AES_STATE_W-1:0]   r_work;
  // Holds in_ready low for the first edge after reset release.
  logic                     r_armed;
  logic                     w_accept;
  logic                     w_last;
  logic [CHUNK_W-1:0]       w_chunk_in;
  logic [CHUNK_W-1:0]       w_chunk_inv;
  logic [CHUNK_W-1:0]       w_chunk_out;

  assign w_accept   = in_valid & in_ready;
  assign w_last     = (r_cnt == LAST_CHUNK);
  assign w_chunk_in = r_work[int'(r_cnt)*CHUNK_W +: CHUNK_W];
  assign out_state  = r_work;

`ifdef INV_SUBBYTES_FWD_EN
  logic               r_mode;
  logic [CHUNK_W-1:0] w_chunk_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= 1'b0;
    end else if (w_accept) begin
      r_mode <= mode;
    end
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = mode;
`endif

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    inv_sbox u_inv_sbox (
      .i_byte (w_chunk_in[g*8 +: 8]),
      .o_byte (w_chunk_inv[g*8 +: 8])
    );
`ifdef INV_SUBBYTES_FWD_EN
    assign w_chunk_fwd[g*8 +: 8] = sbox_fwd(w_chunk_in[g*8 +: 8]);
    assign w_chunk_out[g*8 +: 8] = r_mode ? w_chunk_fwd[g*8 +: 8] : w_chunk_inv[g*8 +: 8];
`else
    assign w_chunk_out[g*8 +: 8] = w_chunk_inv[g*8 +: 8];
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_BUSY;
      ST_BUSY: if (w_last)   w_next_state = ST_DONE;
      ST_DONE: begin
        if (w_accept)       w_next_state = ST_BUSY;
        else if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs; in DONE the input side opens only when the result is leaving.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: in_ready  = r_armed;
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = r_armed & out_ready;
      end
      default: ;
    endcase
  end

  // Working register and chunk counter; chunks are rewritten in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_work  <= '0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_work <= in_state;
        r_cnt  <= '0;
      end else if (r_state == ST_BUSY) begin
        r_work[int'(r_cnt)*CHUNK_W +: CHUNK_W] <= w_chunk_out;
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inv_subbytes_iter.sv
// tb/tb_inv_subbytes_iter.sv - self-checking bench for inv_subbytes_iter at BPC 1/2/4/8/16
module tb_inv_subbytes_iter;

  // Instance g has BYTES_PER_CYCLE = 1 << g; instance 2 (BPC=4) is the main one.
  localparam int MAIN = 2;
  localparam int BOUND = 40;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   in_valid;
  logic [4:0]   in_ready;
  logic [4:0]   out_valid;
  logic [4:0]   out_ready;
  logic [127:0] in_state;
  logic         mode;
  logic [127:0] out_state [5];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_subbytes_iter #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state),
      .mode      (mode),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g])
    );
  end

  typedef struct {
    int           idx;
    logic [127:0] data;
  } exp_t;

  typedef struct {
    int           idx;
    logic [127:0] din;
    logic         m;
    logic [127:0] dexp;
    int           lat;
  } vec_t;

  localparam logic [127:0] V63   = 128'h63636363636363636363636363636363;
  localparam logic [127:0] VSB   = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] VIDX  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] VIDXI = 128'hfbd7f3819ea340bf38a53630d56a0952;
  localparam logic [127:0] VHI   = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;
  localparam logic [127:0] VHII  = 128'h7d0c2155631469e126d677ba7e042b17;
`ifdef INV_SUBBYTES_FWD_EN
  localparam logic [127:0] VMODE1 = VSB;
`else
  localparam logic [127:0] VMODE1 = VIDXI;
`endif

  exp_t sb_q[$];
  vec_t vecs[10];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Compare the current output of instance idx with the oldest expectation.
  task automatic pop_check(input int idx, input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({name, "_unexpected_output"}, 128'd1, 128'd0);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_idx"}, 128'(idx), 128'(e.idx));
      chk({name, "_data"}, out_state[idx], e.data);
    end
  endtask

  // Present data and return just after the accepting edge.
  task automatic send(input int idx, input logic [127:0] d, input logic m, output bit ok);
    ok = 1'b0;
    in_state = d;
    mode = m;
    in_valid[idx] = 1'b1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (in_ready[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1 in_valid[idx] = 1'b0;
  endtask

  // Latency counts rising edges from the accept edge through the edge raising out_valid.
  task automatic wait_out(input int idx, output int cnt);
    cnt = 1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (out_valid[idx]) return;
      @(posedge clk);
      cnt++;
    end
    cnt = -1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bit ok;
    int cnt;
    exp_t e;
    e.idx = v.idx;
    e.data = v.dexp;
    sb_q.push_back(e);
    send(v.idx, v.din, v.m, ok);
    wait_out(v.idx, cnt);
    chk({name, "_latency"}, 128'(cnt), 128'(v.lat));
    if (cnt > 0) pop_check(v.idx, name);
    else void'(sb_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    int cnt;
    exp_t e;
    logic [127:0] held;

    vecs[0] = '{MAIN, V63,  1'b0, 128'h0, 5};
    vecs[1] = '{MAIN, VSB,  1'b0, VIDX,   5};
    vecs[2] = '{0,    VSB,  1'b0, VIDX,   17};
    vecs[3] = '{1,    VSB,  1'b0, VIDX,   9};
    vecs[4] = '{3,    VSB,  1'b0, VIDX,   3};
    vecs[5] = '{4,    VSB,  1'b0, VIDX,   2};
    vecs[6] = '{MAIN, VIDX, 1'b0, VIDXI,  5};
    vecs[7] = '{MAIN, VHI,  1'b0, VHII,   5};
    vecs[8] = '{MAIN, VIDX, 1'b1, VMODE1, 5};
    vecs[9] = '{4,    VHI,  1'b0, VHII,   2};

    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '1;
    in_state = '0;
    mode = 1'b0;
    #12;
    for (int g = 0; g < 5; g++) begin
      chk("reset_in_ready", 128'(in_ready[g]), 128'd0);
      chk("reset_out_valid", 128'(out_valid[g]), 128'd0);
    end
    chk("reset_out_state", out_state[MAIN], 128'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready_low", 128'(in_ready[MAIN]), 128'd0);
    @(negedge clk);
    chk("release_in_ready_high", 128'(in_ready[MAIN]), 128'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Output stalled in DONE: result held, no new accept.
    out_ready[MAIN] = 1'b0;
    e.idx = MAIN;
    e.data = VIDX;
    sb_q.push_back(e);
    send(MAIN, VSB, 1'b0, ok);
    wait_out(MAIN, cnt);
    chk("stall_latency", 128'(cnt), 128'd5);
    held = out_state[MAIN];
    in_state = V63;
    in_valid[MAIN] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_out_state", out_state[MAIN], held);
      chk("stall_out_valid", 128'(out_valid[MAIN]), 128'd1);
      chk("stall_in_ready", 128'(in_ready[MAIN]), 128'd0);
    end
    in_valid[MAIN] = 1'b0;
    out_ready[MAIN] = 1'b1;
    #1 pop_check(MAIN, "stall");
    @(negedge clk);
    chk("stall_to_idle_out_valid", 128'(out_valid[MAIN]), 128'd0);
    chk("stall_to_idle_in_ready", 128'(in_ready[MAIN]), 128'd1);
    @(posedge clk);
    #1;

    // Back-to-back: B offered during BUSY, accepted on A's output handshake.
    e.data = 128'h0;
    sb_q.push_back(e);
    e.data = VHII;
    sb_q.push_back(e);
    send(MAIN, V63, 1'b0, ok);
    in_state = VHI;
    in_valid[MAIN] = 1'b1;
    wait_out(MAIN, cnt);
    chk("b2b_a_latency", 128'(cnt), 128'd5);
    chk("b2b_same_cycle_in_ready", 128'(in_ready[MAIN]), 128'd1);
    pop_check(MAIN, "b2b_a");
    @(posedge clk);
    #1 in_valid[MAIN] = 1'b0;
    wait_out(MAIN, cnt);
    chk("b2b_b_latency", 128'(cnt), 128'd5);
    pop_check(MAIN, "b2b_b");
    @(posedge clk);
    #1;

    // Reset mid-BUSY with the counter at 2; the operation must be dropped.
    send(MAIN, VSB, 1'b0, ok);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid[MAIN]), 128'd0);
    chk("midrst_in_ready", 128'(in_ready[MAIN]), 128'd0);
    chk("midrst_out_state", out_state[MAIN], 128'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_in_ready_low", 128'(in_ready[MAIN]), 128'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("midrst_no_output", 128'(out_valid[MAIN]), 128'd0);
    end
    chk("midrst_in_ready_high", 128'(in_ready[MAIN]), 128'd1);
    run_vec('{MAIN, {16{8'h16}}, 1'b0, {16{8'hff}}, 5}, "after_reset");

    chk("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
